// File: rtl/region_feed_scheduler.sv
//------------------------------------------------------------------------------
// Module  : region_feed_scheduler
// Brief   : Round-robin two-source record arbiter that serialises 64-bit
//           region records onto the 32-bit fit-check word stream (low word
//           first). Optional per-source counters: REGION_FEED_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module region_feed_scheduler #(
  parameter int NUM_REGIONS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        a_valid,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [63:0] b_data,
  output logic        b_ready,
  output logic        fit_clear,
  output logic [31:0] fit_data,
  output logic        fit_valid,
  input  logic        fit_ready,
  input  logic        fit_finished,
  input  logic [63:0] fit_result,
  output logic        busy,
  output logic        done,
  output logic [63:0] total,
  output logic [31:0] count_a,
  output logic [31:0] count_b
);

  localparam logic [15:0] c_num_regions = 16'(NUM_REGIONS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_accepted;
  logic [63:0] r_hold;
  logic        r_hold_valid;
  logic        r_phase_high;
  logic        r_last_b;
  logic        r_fit_clear;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_total;

  logic w_start_ok;
  logic w_xfer;
  logic w_load_slot;
  logic w_grant_a;
  logic w_grant_b;
  logic w_last_word;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer      = r_hold_valid && fit_ready;
  // A new record may only be captured once the held one is fully leaving.
  assign w_load_slot = (r_state == S_RUN) && (r_accepted < c_num_regions) &&
                       (!r_hold_valid || (r_phase_high && fit_ready));
  assign w_grant_a   = w_load_slot && a_valid && (!b_valid || r_last_b);
  assign w_grant_b   = w_load_slot && b_valid && (!a_valid || !r_last_b);
  assign w_last_word = (r_state == S_RUN) && w_xfer && r_phase_high &&
                       (r_accepted == c_num_regions);

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign fit_valid = r_hold_valid;
  assign fit_data  = r_phase_high ? r_hold[63:32] : r_hold[31:0];
  assign fit_clear = r_fit_clear;
  assign busy      = r_busy;
  assign done      = r_done;
  assign total     = r_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_accepted   <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_phase_high <= 1'b0;
      r_last_b     <= 1'b1;
      r_fit_clear  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_total      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state      <= S_CLEAR;
            r_accepted   <= '0;
            r_hold_valid <= 1'b0;
            r_phase_high <= 1'b0;
            r_last_b     <= 1'b1;
            r_total      <= '0;
            r_fit_clear  <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_state     <= S_RUN;
          r_fit_clear <= 1'b0;
        end
        S_RUN: begin
          if (w_grant_a || w_grant_b) begin
            r_hold       <= w_grant_a ? a_data : b_data;
            r_hold_valid <= 1'b1;
            r_phase_high <= 1'b0;
            r_accepted   <= r_accepted + 16'd1;
            r_last_b     <= w_grant_b;
          end else if (w_xfer) begin
            if (!r_phase_high) begin
              r_phase_high <= 1'b1;
            end else begin
              r_hold_valid <= 1'b0;
            end
          end
          if (w_last_word) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fit_finished) begin
            r_total <= fit_result;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGION_FEED_STATS_EN
  logic [15:0] r_count_a;
  logic [15:0] r_count_b;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_count_a <= '0;
      r_count_b <= '0;
    end else begin
      if (w_grant_a) r_count_a <= r_count_a + 16'd1;
      if (w_grant_b) r_count_b <= r_count_b + 16'd1;
    end
  end

  assign count_a = {16'd0, r_count_a};
  assign count_b = {16'd0, r_count_b};
`else
  assign count_a = '0;
  assign count_b = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_region_feed_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_region_feed_scheduler
// Brief   : Bench for region_feed_scheduler; a queue-of-words reference model
//           is compared against the DUT on every cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_region_feed_scheduler;

  localparam int N = 6;
`ifdef REGION_FEED_STATS_EN
  localparam bit c_stats = 1'b1;
`else
  localparam bit c_stats = 1'b0;
`endif

  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst, start, a_valid, b_valid, fit_ready, fit_finished;
  logic [63:0] a_data, b_data, fit_result, total;
  logic        a_ready, b_ready, fit_clear, fit_valid, busy, done;
  logic [31:0] fit_data, count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  region_feed_scheduler #(.NUM_REGIONS(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .fit_clear(fit_clear), .fit_data(fit_data), .fit_valid(fit_valid),
    .fit_ready(fit_ready), .fit_finished(fit_finished), .fit_result(fit_result),
    .busy(busy), .done(done), .total(total),
    .count_a(count_a), .count_b(count_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a queue of pending words plus a few counters.
  int          m_st;
  bit          m_known = 1'b0;
  int          m_acc;
  bit          m_last_b;
  logic [31:0] m_q[$];
  logic [63:0] m_total;
  int          m_cnt_a, m_cnt_b;
  bit          m_clear;
  int          clear_pulses;
  logic [31:0] word_log[$];
  bit          grant_seq[$];

  task automatic model_reset();
    m_st = M_IDLE; m_acc = 0; m_last_b = 1'b1; m_q.delete();
    m_total = '0; m_cnt_a = 0; m_cnt_b = 0; m_clear = 1'b0;
  endtask

  initial begin : p_model
    bit slot, ga, gb, xf;
    forever begin
      @(negedge clk);
      xf   = (m_q.size() != 0) && (fit_ready === 1'b1);
      slot = (m_st == M_RUN) && (m_acc < N) &&
             ((m_q.size() == 0) || ((m_q.size() == 1) && (fit_ready === 1'b1)));
      ga   = slot && (a_valid === 1'b1) && ((b_valid !== 1'b1) || m_last_b);
      gb   = slot && (b_valid === 1'b1) && ((a_valid !== 1'b1) || !m_last_b);
      if (m_known) begin
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("fit_valid", fit_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("fit_data", fit_data, m_q[0]);
        check("fit_clear", fit_clear, m_clear);
        check("busy", busy, (m_st == M_CLEAR) || (m_st == M_RUN) || (m_st == M_DRAIN));
        check("done", done, m_st == M_DONE);
        check("total", total, m_total);
        check("count_a", count_a, c_stats ? 64'(m_cnt_a) : 64'd0);
        check("count_b", count_b, c_stats ? 64'(m_cnt_b) : 64'd0);
        if (fit_clear === 1'b1) clear_pulses++;
      end
      if (rst === 1'b1) begin
        model_reset();
        m_known = 1'b1;
      end else if (m_known) begin
        case (m_st)
          M_IDLE, M_DONE: if (start === 1'b1) begin
            model_reset();
            m_st = M_CLEAR; m_clear = 1'b1;
          end
          M_CLEAR: begin m_st = M_RUN; m_clear = 1'b0; end
          M_RUN: begin
            if (xf) begin
              word_log.push_back(m_q.pop_front());
              if ((m_q.size() == 0) && (m_acc == N)) m_st = M_DRAIN;
            end
            if (ga) begin
              m_q.push_back(a_data[31:0]); m_q.push_back(a_data[63:32]);
              m_acc++; m_last_b = 1'b0; m_cnt_a++; grant_seq.push_back(1'b0);
            end
            if (gb) begin
              m_q.push_back(b_data[31:0]); m_q.push_back(b_data[63:32]);
              m_acc++; m_last_b = 1'b1; m_cnt_b++; grant_seq.push_back(1'b1);
            end
          end
          M_DRAIN: if (fit_finished === 1'b1) begin
            m_total = fit_result; m_st = M_DONE;
          end
          default: m_st = M_IDLE;
        endcase
      end
    end
  end

  // Sources: record k of a source carries words base+2k (low) and base+2k+1.
  int          a_mode = 0, b_mode = 0, fr_mode = 0;
  logic [31:0] a_idx, b_idx;

  initial begin : p_drive
    a_idx = '0; b_idx = '0;
    a_valid = 1'b0; b_valid = 1'b0; fit_ready = 1'b0;
    a_data = '0; b_data = '0;
    forever begin
      @(negedge clk);
      if ((a_valid === 1'b1) && (a_ready === 1'b1)) a_idx++;
      if ((b_valid === 1'b1) && (b_ready === 1'b1)) b_idx++;
      @(posedge clk);
      #2;
      a_valid   = (a_mode == 2) ? 1'($urandom_range(0, 1)) : (a_mode == 1);
      b_valid   = (b_mode == 2) ? 1'($urandom_range(0, 1)) : (b_mode == 1);
      fit_ready = (fr_mode == 2) ? ($urandom_range(0, 3) != 0) : (fr_mode == 1);
      a_data    = {32'hA000_0000 + 32'd2 * a_idx + 32'd1, 32'hA000_0000 + 32'd2 * a_idx};
      b_data    = {32'hB000_0000 + 32'd2 * b_idx + 32'd1, 32'hB000_0000 + 32'd2 * b_idx};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout expected progress", name);
  endtask

  task automatic finish_run(input logic [63:0] res, input int delay);
    for (int i = 0; i < 400 && m_st != M_DRAIN; i++) tick();
    if (m_st != M_DRAIN) timeout_fail("reach_drain");
    repeat (delay) tick();
    fit_finished = 1'b1;
    fit_result   = res;
    tick();
    fit_finished = 1'b0;
    fit_result   = {$urandom, $urandom};
    @(negedge clk);
    check("run_done", done, 1'b1);
    check("run_total", total, res);
  endtask

  initial begin : p_main
    logic [31:0] base;
    logic [11:0] pattern;
    logic [5:0]  gseq;
    rst = 1'b1; start = 1'b0; fit_finished = 1'b0; fit_result = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_total", total, 64'd0);
    check("rst_fit_valid", fit_valid, 1'b0);
    check("rst_fit_data", fit_data, 32'd0);
    check("rst_fit_clear", fit_clear, 1'b0);

    // A only, full-rate sink: back-to-back records, ready on even RUN cycles.
    a_mode = 1; b_mode = 0; fr_mode = 1;
    tick();
    base = a_idx;
    word_log.delete();
    pulse_start();
    @(negedge clk);
    check("s1_clear_pulse", fit_clear, 1'b1);
    pattern = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pattern[c] = a_ready;
    end
    check("s1_ready_pattern", 64'(pattern), 64'h555);
    finish_run(64'd3, 0);
    check("s1_word_count", word_log.size(), 12);
    for (int j = 0; j < word_log.size() && j < 12; j++)
      check("s1_word", word_log[j], 32'hA000_0000 + 32'd2 * base + 32'(j));

    // Both sources continuously valid: strict alternation starting with A.
    a_mode = 1; b_mode = 1; fr_mode = 1;
    tick();
    grant_seq.delete();
    pulse_start();
    finish_run(64'h1234_5678_9abc_def0, 2);
    gseq = '0;
    for (int j = 0; j < grant_seq.size() && j < 6; j++) gseq[j] = grant_seq[j];
    check("s2_grant_seq", 64'(gseq), 64'h2A);
    check("s2_count_a", count_a, c_stats ? 64'd3 : 64'd0);
    check("s2_count_b", count_b, c_stats ? 64'd3 : 64'd0);

    // Stall in HIGH phase for 5 cycles; stray start and finished are ignored.
    a_mode = 1; b_mode = 0; fr_mode = 1;
    tick();
    base = a_idx;
    pulse_start();
    repeat (3) @(negedge clk);
    tick();
    fr_mode = 0; start = 1'b1; fit_finished = 1'b1; fit_result = 64'hDEAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("s3_hold_data", fit_data, 32'hA000_0000 + 32'd2 * base + 32'd1);
      check("s3_no_grant", a_ready | b_ready, 1'b0);
      tick();
      start = 1'b0; fit_finished = 1'b0;
    end
    fr_mode = 2;
    finish_run(64'd3, 1);

    // Reset after two records, then a clean full run.
    a_mode = 1; b_mode = 0; fr_mode = 1;
    tick();
    grant_seq.delete();
    pulse_start();
    for (int i = 0; i < 50 && grant_seq.size() < 2; i++) tick();
    if (grant_seq.size() < 2) timeout_fail("s5_two_grants");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s5_busy", busy, 1'b0);
    check("s5_fit_valid", fit_valid, 1'b0);
    check("s5_fit_data", fit_data, 32'd0);
    check("s5_ready", a_ready, 1'b0);
    check("s5_clear", fit_clear, 1'b0);
    tick();
    clear_pulses = 0;
    grant_seq.delete();
    pulse_start();
    finish_run(64'd5, 0);
    check("s5_clear_pulses", clear_pulses, 1);
    check("s5_grants", grant_seq.size(), N);

    // Back-to-back randomized runs from DONE.
    a_mode = 2; b_mode = 2; fr_mode = 2;
    for (int r = 0; r < 4; r++) begin
      tick();
      grant_seq.delete();
      pulse_start();
      @(negedge clk);
      check("s6_total_cleared", total, 64'd0);
      check("s6_clear_pulse", fit_clear, 1'b1);
      finish_run({$urandom, $urandom}, $urandom_range(0, 3));
      check("s6_grants", grant_seq.size(), N);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

`default_nettype wire
